// File: rtl/hssio_link_ctrl.sv
// Bring-up sequencer and link monitor for the native-mode HSSIO TX/RX loopback pair.
// Steps PLL/reset -> delay ready -> VTC -> settle, trains on a ramp, then watches the RX stream.
module hssio_link_ctrl #(
    parameter int unsigned NUM_BSC    = 3,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned SETTLE     = 64,
    parameter int unsigned TRAIN_LEN  = 32,
    parameter int unsigned ERR_THRESH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               rst_seq_done,
    input  logic [NUM_BSC-1:0] dly_rdy,
    input  logic [NUM_BSC-1:0] vtc_rdy,
    output logic [NUM_BSC-1:0] en_vtc,
    input  logic [7:0]         usr_data,
    output logic [7:0]         tx_data,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               retrain,
    output logic               link_up,
    output logic               timeout,
    output logic [2:0]         state,
    output logic [15:0]        err_cnt
);

    localparam int unsigned TMR_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned GOOD_W  = $clog2(TRAIN_LEN + 1);
    localparam int unsigned BAD_W   = $clog2(ERR_THRESH + 1);

    localparam logic [2:0] S_RST      = 3'd0;
    localparam logic [2:0] S_WAIT_PLL = 3'd1;
    localparam logic [2:0] S_WAIT_DLY = 3'd2;
    localparam logic [2:0] S_WAIT_VTC = 3'd3;
    localparam logic [2:0] S_SETTLE   = 3'd4;
    localparam logic [2:0] S_TRAIN    = 3'd5;
    localparam logic [2:0] S_RUN      = 3'd6;
    localparam logic [2:0] S_FAIL     = 3'd7;

    logic [2:0]        state_nx;
    logic [TMR_W-1:0]  tmr;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic              seeded;
    logic [7:0]        prev_byte;

    logic              state_chg_c;
    logic              tmo_hit_c;
    logic              settle_done_c;
    logic              rx_active_c;
    logic              rx_fire_c;
    logic              rx_chk_c;
    logic              rx_match_c;
    logic [7:0]        exp_byte_c;
    logic              vtc_on_c;

    // RX datapath qualifiers: a byte is only consumed when the FIFO actually has one
    always_comb begin
        rx_active_c   = (state == S_TRAIN) || (state == S_RUN);
        fifo_rd_en    = ~fifo_empty & rx_active_c;
        rx_fire_c     = rx_valid & ~fifo_empty & rx_active_c;
        rx_chk_c      = rx_fire_c & seeded;
        exp_byte_c    = prev_byte + 8'd1;
        rx_match_c    = (rx_data == exp_byte_c);
        tmo_hit_c     = (tmr == TMR_W'(TIMEOUT - 1));
        settle_done_c = (tmr == TMR_W'(SETTLE - 1));
    end

    // Next-state logic; retrain overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            S_RST:      state_nx = S_WAIT_PLL;
            S_WAIT_PLL: begin
                if (pll_locked && rst_seq_done) state_nx = S_WAIT_DLY;
                else if (tmo_hit_c)             state_nx = S_FAIL;
            end
            S_WAIT_DLY: begin
                if (!pll_locked)     state_nx = S_RST;
                else if (&dly_rdy)   state_nx = S_WAIT_VTC;
                else if (tmo_hit_c)  state_nx = S_FAIL;
            end
            S_WAIT_VTC: begin
                if (!pll_locked)     state_nx = S_RST;
                else if (&vtc_rdy)   state_nx = S_SETTLE;
                else if (tmo_hit_c)  state_nx = S_FAIL;
            end
            S_SETTLE: begin
                if (!pll_locked)        state_nx = S_RST;
                else if (settle_done_c) state_nx = S_TRAIN;
            end
            S_TRAIN: begin
                if (!pll_locked)                            state_nx = S_RST;
                else if (good_cnt == GOOD_W'(TRAIN_LEN))    state_nx = S_RUN;
                else if (tmo_hit_c)                         state_nx = S_FAIL;
            end
            S_RUN: begin
                if (!pll_locked)                            state_nx = S_RST;
                else if (bad_cnt == BAD_W'(ERR_THRESH))     state_nx = S_TRAIN;
            end
            S_FAIL:     state_nx = S_FAIL;
            default:    state_nx = S_RST;
        endcase
        if (retrain) state_nx = S_RST;
    end

    always_comb begin
        state_chg_c = (state_nx != state);
        vtc_on_c    = (state_nx == S_WAIT_VTC) || (state_nx == S_SETTLE) ||
                      (state_nx == S_TRAIN)    || (state_nx == S_RUN);
    end

    // State register, per-state timer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RST;
            tmr      <= '0;
            en_vtc   <= '0;
            link_up  <= 1'b0;
            timeout  <= 1'b0;
            tx_data  <= 8'd0;
        end else begin
            state    <= state_nx;
            if (state_chg_c)      tmr <= '0;
            else if (tmr != '1)   tmr <= tmr + TMR_W'(1);
            en_vtc   <= vtc_on_c ? '1 : '0;
            link_up  <= (state_nx == S_RUN);
            // FAIL is only ever reached through a timeout
            timeout  <= (state_nx == S_FAIL);
            if (state_nx == S_TRAIN)
                tx_data <= (state == S_TRAIN) ? tx_data + 8'd1 : 8'd0;
            else if (state_nx == S_RUN)
                tx_data <= usr_data;
            else
                tx_data <= 8'd0;
        end
    end

    // RX stream checker: first byte after state entry seeds, expected always reseeds
    always_ff @(posedge clk) begin
        if (reset) begin
            seeded    <= 1'b0;
            prev_byte <= 8'd0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else if (state_chg_c) begin
            seeded    <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else if (rx_fire_c) begin
            seeded    <= 1'b1;
            prev_byte <= rx_data;
            if (rx_chk_c && state == S_TRAIN) begin
                if (!rx_match_c)                            good_cnt <= '0;
                else if (good_cnt != GOOD_W'(TRAIN_LEN))    good_cnt <= good_cnt + GOOD_W'(1);
            end
            if (rx_chk_c && state == S_RUN) begin
                if (rx_match_c)                             bad_cnt <= '0;
                else if (bad_cnt != BAD_W'(ERR_THRESH))     bad_cnt <= bad_cnt + BAD_W'(1);
            end
        end
    end

    // Lifetime mismatch count, cleared only while sitting in RST
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 16'd0;
        end else if (state == S_RST) begin
            err_cnt <= 16'd0;
        end else if (rx_chk_c && state == S_RUN && !rx_match_c && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hssio_link_ctrl.sv
// Self-checking bench for hssio_link_ctrl: bring-up, timeout, RX error handling, resets.
module tb_hssio_link_ctrl;

    localparam int unsigned NUM_BSC    = 3;
    localparam int unsigned TIMEOUT    = 300;
    localparam int unsigned SETTLE     = 64;
    localparam int unsigned TRAIN_LEN  = 32;
    localparam int unsigned ERR_THRESH = 4;

    localparam logic [2:0] S_RST      = 3'd0;
    localparam logic [2:0] S_WAIT_PLL = 3'd1;
    localparam logic [2:0] S_WAIT_DLY = 3'd2;
    localparam logic [2:0] S_WAIT_VTC = 3'd3;
    localparam logic [2:0] S_SETTLE   = 3'd4;
    localparam logic [2:0] S_TRAIN    = 3'd5;
    localparam logic [2:0] S_RUN      = 3'd6;
    localparam logic [2:0] S_FAIL     = 3'd7;

    logic               clk;
    logic               reset;
    logic               pll_locked;
    logic               rst_seq_done;
    logic [NUM_BSC-1:0] dly_rdy;
    logic [NUM_BSC-1:0] vtc_rdy;
    logic [NUM_BSC-1:0] en_vtc;
    logic [7:0]         usr_data;
    logic [7:0]         tx_data;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               retrain;
    logic               link_up;
    logic               timeout;
    logic [2:0]         state;
    logic [15:0]        err_cnt;

    hssio_link_ctrl #(
        .NUM_BSC(NUM_BSC), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE),
        .TRAIN_LEN(TRAIN_LEN), .ERR_THRESH(ERR_THRESH)
    ) dut (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .rst_seq_done(rst_seq_done),
        .dly_rdy(dly_rdy), .vtc_rdy(vtc_rdy), .en_vtc(en_vtc), .usr_data(usr_data),
        .tx_data(tx_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .rx_valid(rx_valid), .rx_data(rx_data), .retrain(retrain), .link_up(link_up),
        .timeout(timeout), .state(state), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] trn_exp;
    bit         trn_valid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of RX stimulus; tx_data is scored against the queued usr_data or train ramp
    task automatic step(input bit v, input logic [7:0] b, input bit empty);
        logic [7:0] exp_tx;
        logic [2:0] last_st;
        last_st    = state;
        rx_valid   = v;
        rx_data    = b;
        fifo_empty = empty;
        usr_data   = 8'($urandom);
        tx_q.push_back(usr_data);
        tick();
        exp_tx = tx_q.pop_front();
        if (state == S_RUN) begin
            chk_cnt++;
            if (tx_data !== exp_tx) $display("FAIL run_tx: tx_data=%h expected %h", tx_data, exp_tx);
            else pass_cnt++;
            trn_valid = 1'b0;
        end else if (state == S_TRAIN) begin
            if (last_st != S_TRAIN) begin
                trn_exp   = 8'd0;
                trn_valid = 1'b1;
            end
            if (trn_valid) begin
                chk_cnt++;
                if (tx_data !== trn_exp) $display("FAIL train_tx: tx_data=%h expected %h", tx_data, trn_exp);
                else pass_cnt++;
                trn_exp = trn_exp + 8'd1;
            end
        end else begin
            trn_valid = 1'b0;
        end
        rx_valid = 1'b0;
    endtask

    task automatic push_ramp(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) rx_q.push_back(8'(start + 8'(i)));
    endtask

    task automatic feed_q();
        while (rx_q.size() > 0) step(1'b1, rx_q.pop_front(), 1'b0);
    endtask

    task automatic bring_up_to_train();
        int n;
        retrain = 1'b1;
        tick();
        retrain      = 1'b0;
        pll_locked   = 1'b1;
        rst_seq_done = 1'b1;
        dly_rdy      = '1;
        vtc_rdy      = '1;
        n = 0;
        while (state != S_TRAIN && n < 500) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (state !== S_TRAIN || tx_data !== 8'd0)
            $display("FAIL reach_train: state=%0d tx_data=%h expected state 5 tx 00", state, tx_data);
        else pass_cnt++;
        trn_exp   = 8'd1;
        trn_valid = 1'b1;
    endtask

    task automatic bring_up();
        bring_up_to_train();
        push_ramp(8'h10, 33);
        feed_q();
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if (state !== S_RUN || link_up !== 1'b1)
            $display("FAIL reach_run: state=%0d link_up=%b expected 6/1", state, link_up);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        chk_cnt++;
        if (state !== S_RST || en_vtc !== '0 || tx_data !== 8'd0 || fifo_rd_en !== 1'b0 ||
            link_up !== 1'b0 || timeout !== 1'b0 || err_cnt !== 16'd0)
            $display("FAIL reset_vals: state=%0d en_vtc=%b tx=%h rd=%b up=%b tmo=%b err=%0d expected all zero",
                     state, en_vtc, tx_data, fifo_rd_en, link_up, timeout, err_cnt);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        chk_cnt++;
        if (state !== S_WAIT_PLL) $display("FAIL rst_exit: state=%0d expected 1", state);
        else pass_cnt++;
    endtask

    task automatic test_bringup();
        int n;
        repeat (9) tick();
        chk_cnt++;
        if (state !== S_WAIT_PLL) $display("FAIL wait_pll_hold: state=%0d expected 1", state);
        else pass_cnt++;
        pll_locked   = 1'b1;
        rst_seq_done = 1'b1;
        tick();
        chk_cnt++;
        if (state !== S_WAIT_DLY || en_vtc !== '0)
            $display("FAIL to_wait_dly: state=%0d en_vtc=%b expected 2/000", state, en_vtc);
        else pass_cnt++;
        repeat (9) tick();
        dly_rdy = 3'b111;
        tick();
        chk_cnt++;
        if (state !== S_WAIT_VTC || en_vtc !== 3'b111)
            $display("FAIL to_wait_vtc: state=%0d en_vtc=%b expected 3/111", state, en_vtc);
        else pass_cnt++;
        repeat (9) tick();
        vtc_rdy = 3'b111;
        tick();
        n = 0;
        while (state == S_SETTLE && n < 1000) begin
            n++;
            tick();
        end
        chk_cnt++;
        if (n != int'(SETTLE) || state !== S_TRAIN || tx_data !== 8'd0)
            $display("FAIL settle_len: cycles=%0d state=%0d tx=%h expected %0d cycles then state 5 tx 00",
                     n, state, tx_data, SETTLE);
        else pass_cnt++;
        trn_exp   = 8'd1;
        trn_valid = 1'b1;
        fifo_empty = 1'b0;
        #1;
        chk_cnt++;
        if (fifo_rd_en !== 1'b1) $display("FAIL rd_en_train: fifo_rd_en=%b expected 1", fifo_rd_en);
        else pass_cnt++;
        fifo_empty = 1'b1;
        #1;
        chk_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL rd_en_empty: fifo_rd_en=%b expected 0", fifo_rd_en);
        else pass_cnt++;
        push_ramp(8'h10, 33);
        feed_q();
        chk_cnt++;
        if (state !== S_TRAIN) $display("FAIL train_33: state=%0d expected 5", state);
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if (state !== S_RUN || link_up !== 1'b1 || err_cnt !== 16'd0 || en_vtc !== 3'b111)
            $display("FAIL link_up: state=%0d up=%b err=%0d en_vtc=%b expected 6/1/0/111",
                     state, link_up, err_cnt, en_vtc);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n;
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        chk_cnt++;
        if (state !== S_RST || link_up !== 1'b0) $display("FAIL retrain_rst: state=%0d up=%b expected 0/0", state, link_up);
        else pass_cnt++;
        dly_rdy = 3'b011;
        vtc_rdy = 3'b000;
        n = 0;
        while (state != S_WAIT_DLY && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (state == S_WAIT_DLY && n < int'(TIMEOUT) + 50) begin
            n++;
            tick();
        end
        chk_cnt++;
        if (n != int'(TIMEOUT) || state !== S_FAIL || timeout !== 1'b1 || en_vtc !== '0)
            $display("FAIL dly_timeout: cycles=%0d state=%0d tmo=%b en_vtc=%b expected %0d/7/1/000",
                     n, state, timeout, en_vtc, TIMEOUT);
        else pass_cnt++;
        dly_rdy = 3'b111;
        repeat (5) tick();
        chk_cnt++;
        if (state !== S_FAIL || timeout !== 1'b1) $display("FAIL fail_hold: state=%0d tmo=%b expected 7/1", state, timeout);
        else pass_cnt++;
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        chk_cnt++;
        if (state !== S_RST || timeout !== 1'b0) $display("FAIL fail_retrain: state=%0d tmo=%b expected 0/0", state, timeout);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        bring_up();
        push_ramp(8'h30, 18);
        rx_q.push_back(8'h00);
        push_ramp(8'h43, 3);
        feed_q();
        chk_cnt++;
        if (err_cnt !== 16'd2 || link_up !== 1'b1 || state !== S_RUN)
            $display("FAIL glitch_err: err=%0d up=%b state=%0d expected 2/1/6", err_cnt, link_up, state);
        else pass_cnt++;
        step(1'b1, 8'hAA, 1'b1);
        chk_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL rd_en_gate: fifo_rd_en=%b expected 0", fifo_rd_en);
        else pass_cnt++;
        step(1'b1, 8'h46, 1'b0);
        chk_cnt++;
        if (err_cnt !== 16'd2) $display("FAIL empty_ignored: err=%0d expected 2", err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_err_thresh();
        bring_up();
        push_ramp(8'h50, 8);
        repeat (ERR_THRESH) rx_q.push_back(8'h80);
        feed_q();
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if (state !== S_TRAIN || link_up !== 1'b0 || err_cnt !== 16'd4 || en_vtc !== 3'b111)
            $display("FAIL thresh_retrain: state=%0d up=%b err=%0d en_vtc=%b expected 5/0/4/111",
                     state, link_up, err_cnt, en_vtc);
        else pass_cnt++;
        push_ramp(8'h00, 33);
        feed_q();
        step(1'b0, 8'h00, 1'b0);
        chk_cnt++;
        if (state !== S_RUN || link_up !== 1'b1 || err_cnt !== 16'd4)
            $display("FAIL thresh_recover: state=%0d up=%b err=%0d expected 6/1/4", state, link_up, err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_pll_drop();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        chk_cnt++;
        if (state !== S_RST || en_vtc !== '0 || timeout !== 1'b0 || link_up !== 1'b0)
            $display("FAIL pll_drop: state=%0d en_vtc=%b tmo=%b up=%b expected 0/000/0/0",
                     state, en_vtc, timeout, link_up);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (state !== S_WAIT_PLL || err_cnt !== 16'd0 || timeout !== 1'b0)
            $display("FAIL pll_restart: state=%0d err=%0d tmo=%b expected 1/0/0", state, err_cnt, timeout);
        else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        bring_up();
        push_ramp(8'hF0, 22);
        feed_q();
        chk_cnt++;
        if (err_cnt !== 16'd0 || state !== S_RUN) $display("FAIL wrap: err=%0d state=%0d expected 0/6", err_cnt, state);
        else pass_cnt++;
        repeat (ERR_THRESH) rx_q.push_back(8'h80);
        feed_q();
        step(1'b0, 8'h00, 1'b0);
        push_ramp(8'h20, 3);
        feed_q();
        chk_cnt++;
        if (state !== S_TRAIN || err_cnt !== 16'd4 || tx_data === 8'd0)
            $display("FAIL mid_train: state=%0d err=%0d tx=%h expected 5/4/nonzero", state, err_cnt, tx_data);
        else pass_cnt++;
        fifo_empty = 1'b0;
        reset = 1'b1;
        tick();
        chk_cnt++;
        if (state !== S_RST || en_vtc !== '0 || tx_data !== 8'd0 || fifo_rd_en !== 1'b0 ||
            link_up !== 1'b0 || timeout !== 1'b0 || err_cnt !== 16'd0)
            $display("FAIL mid_train_reset: state=%0d en_vtc=%b tx=%h rd=%b up=%b tmo=%b err=%0d expected all zero",
                     state, en_vtc, tx_data, fifo_rd_en, link_up, timeout, err_cnt);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        chk_cnt++;
        if (state !== S_WAIT_PLL) $display("FAIL post_reset: state=%0d expected 1", state);
        else pass_cnt++;
    endtask

    initial begin
        reset        = 1'b1;
        pll_locked   = 1'b0;
        rst_seq_done = 1'b0;
        dly_rdy      = '0;
        vtc_rdy      = '0;
        usr_data     = 8'd0;
        fifo_empty   = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'd0;
        retrain      = 1'b0;
        trn_exp      = 8'd0;
        trn_valid    = 1'b0;
        test_reset();
        test_bringup();
        test_timeout();
        test_glitch();
        test_err_thresh();
        test_pll_drop();
        test_wrap_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
